// File: rtl/count_seq_ctrl_if.sv
// Key/counter/display bundle for the run-pause-lap sequencer.
// master drives the buttons and the live count; slave is the sequencer itself.
interface count_seq_ctrl_if;
  logic        btn_ss;
  logic        btn_lap;
  logic        btn_rst;
  logic [15:0] count_in;
  logic        cnt_enable;
  logic        cnt_clear_n;
  logic [15:0] disp_q;
  logic        running;
  logic        tc;
  logic [2:0]  state_o;

  modport master (
    output btn_ss, btn_lap, btn_rst, count_in,
    input  cnt_enable, cnt_clear_n, disp_q, running, tc, state_o
  );

  modport slave (
    input  btn_ss, btn_lap, btn_rst, count_in,
    output cnt_enable, cnt_clear_n, disp_q, running, tc, state_o
  );
endinterface

// File: rtl/count_seq_ctrl.sv
// Run/pause/lap/reset sequencer for the 16-bit counter and its 7-segment readout.
// Optional COUNT_SEQ_TC_STOP_EN: stop in DONE at terminal count instead of wrapping.
module count_seq_ctrl #(
  parameter int          PRESCALE   = 50000000,
  parameter int          PRESCALE_W = 26,
  parameter logic [15:0] LIMIT      = 16'hFFFF
) (
  input  logic           clock,
  input  logic           clear,
  count_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [2:0]            r_s1, r_s2, r_prev;   // bit 0 ss, bit 1 lap, bit 2 rst
  logic [PRESCALE_W-1:0] r_presc;
  logic [15:0]           r_snap;
  logic                  r_clr_pulse;

  logic [2:0] w_btn, w_evt;
  logic       w_ev_rst, w_ev_ss, w_ev_lap;
  logic       w_active, w_wrap, w_tc, w_stop;

  assign w_btn    = {bus.btn_rst, bus.btn_lap, bus.btn_ss};
  assign w_evt    = r_s2 & ~r_prev;
  // rst beats ss beats lap; losers in the same cycle are dropped
  assign w_ev_rst = w_evt[2];
  assign w_ev_ss  = w_evt[0] & ~w_evt[2];
  assign w_ev_lap = w_evt[1] & ~w_evt[0] & ~w_evt[2];

  assign w_active = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_wrap   = w_active && (r_presc == PRESCALE_W'(PRESCALE - 1));
  assign w_tc     = w_wrap && (bus.count_in == LIMIT);

`ifdef COUNT_SEQ_TC_STOP_EN
  assign w_stop = w_tc;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state     <= ST_IDLE;
      r_s1        <= '0;
      r_s2        <= '0;
      r_prev      <= '0;
      r_presc     <= '0;
      r_snap      <= '0;
      r_clr_pulse <= 1'b0;
    end else begin
      r_s1        <= w_btn;
      r_s2        <= r_s1;
      r_prev      <= r_s2;
      r_clr_pulse <= 1'b0;
      // prescaler only moves while counting, so PAUSE keeps its phase
      if (w_active)
        r_presc <= w_wrap ? '0 : r_presc + 1'b1;

      if (w_ev_rst) begin
        r_state <= ST_IDLE;
        if (r_state != ST_IDLE) begin
          r_clr_pulse <= 1'b1;
          r_presc     <= '0;
        end
      end else if (w_stop) begin
        r_state <= ST_DONE;
      end else begin
        case (r_state)
          ST_IDLE:  if (w_ev_ss) r_state <= ST_RUN;
          ST_RUN: begin
            if (w_ev_ss)
              r_state <= ST_PAUSE;
            else if (w_ev_lap) begin
              r_state <= ST_LAP;
              r_snap  <= bus.count_in;
            end
          end
          ST_LAP: begin
            if (w_ev_ss)       r_state <= ST_PAUSE;
            else if (w_ev_lap) r_state <= ST_RUN;
          end
          ST_PAUSE: if (w_ev_ss) r_state <= ST_RUN;
          ST_DONE:  r_state <= ST_DONE;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // clear is combinational so the counter is held cleared throughout reset
  assign bus.cnt_clear_n = ~(clear | r_clr_pulse);
  assign bus.cnt_enable  = w_wrap & ~w_stop;
  assign bus.tc          = w_tc;
  assign bus.running     = w_active;
  assign bus.disp_q      = (r_state == ST_LAP) ? r_snap : bus.count_in;
  assign bus.state_o     = r_state;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Randomized bench for count_seq_ctrl against a cycle-level behavioural model.
// Uses PRESCALE=4, LIMIT=3 and a wrapping 16-bit counter model driving count_in.
module tb_count_seq_ctrl;
  localparam int          P     = 4;
  localparam logic [15:0] LIMIT = 16'h0003;
`ifdef COUNT_SEQ_TC_STOP_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [15:0] cnt   = '0;
  int          total = 0;
  int          bad   = 0;

  // model state: state code, cycles spent counting, snapshot, clear pulse, button history
  int          m_state = 0;
  int          m_run   = 0;
  logic [15:0] m_snap  = '0;
  bit          m_clr   = 1'b0;
  bit          hist [3][3];

  count_seq_ctrl_if bus();

  count_seq_ctrl #(.PRESCALE(P), .PRESCALE_W(3), .LIMIT(LIMIT)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  assign bus.count_in = cnt;

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_run   = 0;
    m_snap  = '0;
    m_clr   = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) hist[i][j] = 1'b0;
  endtask

  // one clock: drive at negedge, check outputs, then advance model past the posedge
  task automatic step(input bit ss, input bit lap, input bit rs, input bit clr);
    bit          tick, e_tc, e_en, stop, act, en_seen, clrn_seen;
    bit          ev [3];
    bit          b  [3];
    logic [15:0] cnt_old;
    @(negedge clock);
    bus.btn_ss  = ss;
    bus.btn_lap = lap;
    bus.btn_rst = rs;
    clear       = clr;
    if (clr) model_reset();
    #1;
    act  = (m_state == 1) || (m_state == 3);
    tick = !clr && act && ((m_run % P) == P - 1);
    e_tc = tick && (cnt == LIMIT);
    stop = STOP && e_tc;
    e_en = tick && !stop;
    chk("state",   {29'd0, bus.state_o}, m_state);
    chk("enable",  {31'd0, bus.cnt_enable}, {31'd0, e_en});
    chk("tc",      {31'd0, bus.tc}, {31'd0, e_tc});
    chk("running", {31'd0, bus.running}, {31'd0, act});
    chk("disp",    {16'd0, bus.disp_q}, {16'd0, (m_state == 3) ? m_snap : cnt});
    chk("clear_n", {31'd0, bus.cnt_clear_n}, {31'd0, !(clr || m_clr)});
    en_seen   = bus.cnt_enable;
    clrn_seen = bus.cnt_clear_n;
    cnt_old   = cnt;
    @(posedge clock);
    #1;
    if (!clrn_seen)   cnt = '0;
    else if (en_seen) cnt = (cnt == LIMIT) ? 16'd0 : cnt + 16'd1;
    if (!clr) begin
      b[0] = ss; b[1] = lap; b[2] = rs;
      for (int i = 0; i < 3; i++) begin
        ev[i]      = hist[i][1] && !hist[i][0];
        hist[i][0] = hist[i][1];
        hist[i][1] = hist[i][2];
        hist[i][2] = b[i];
      end
      m_clr = 1'b0;
      if (act) m_run++;
      if (ev[2]) begin
        if (m_state != 0) begin
          m_clr = 1'b1;
          m_run = 0;
        end
        m_state = 0;
      end else if (stop) begin
        m_state = 4;
      end else if (ev[0]) begin
        case (m_state)
          0: m_state = 1;
          1: m_state = 2;
          2: m_state = 1;
          3: m_state = 2;
          default: ;
        endcase
      end else if (ev[1]) begin
        if (m_state == 1) begin
          m_state = 3;
          m_snap  = cnt_old;
        end else if (m_state == 3) m_state = 1;
      end
    end
  endtask

  task automatic hold(input bit ss, input bit lap, input bit rs, input int n);
    for (int i = 0; i < n; i++) step(ss, lap, rs, 1'b0);
  endtask

  initial begin
    bit r_ss, r_lap, r_rs, r_clr;
    bus.btn_ss  = 1'b0;
    bus.btn_lap = 1'b0;
    bus.btn_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    hold(0, 0, 0, 3);
    // start, run, lap, pause, resume
    hold(1, 0, 0, 3);
    hold(0, 0, 0, 22);
    hold(0, 1, 0, 2);
    hold(0, 0, 0, 14);
    hold(1, 0, 0, 2);
    hold(0, 0, 0, 10);
    hold(1, 0, 0, 2);
    hold(0, 0, 0, 9);
    // rst and ss together, then a long held ss
    hold(1, 0, 1, 3);
    hold(0, 0, 0, 8);
    hold(1, 0, 0, 100);
    hold(0, 0, 0, 30);
    // clear mid-count
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    hold(1, 0, 0, 2);
    hold(0, 0, 0, 40);
    hold(0, 0, 1, 2);
    hold(0, 0, 0, 6);
    r_ss = 0; r_lap = 0; r_rs = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0)  r_ss  = ~r_ss;
      if ($urandom_range(9) == 0)  r_lap = ~r_lap;
      if ($urandom_range(59) == 0) r_rs  = ~r_rs;
      r_clr = ($urandom_range(599) == 0);
      step(r_ss, r_lap, r_rs, r_clr);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
